// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine sequencing logic.
//   vm_state_e : FSM state encoding, also shown on the display port
//   COIN_100/COIN_500 : coin denominations in currency units
package vm_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vm_state_e;

    localparam int unsigned COIN_100 = 100;
    localparam int unsigned COIN_500 = 500;

endpackage

// File: rtl/vm_change_unit.sv
// Change payout sequencer: alternates pulse slots and gap cycles while the
// controller sits in CHANGE, paying the largest coin that fits the credit.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_start         : controller enters CHANGE on this edge; arms the first slot
//   i_active        : controller is currently in CHANGE
//   i_credit        : credit value to pay out from (controller's register)
//   o_change500/100 : next-state payout strobes (registered by the controller)
//   o_done          : credit exhausted, controller may return to IDLE
//   o_credit        : credit after this cycle's payout
module vm_change_unit
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W = 12
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_active,
    input  logic [CREDIT_W-1:0] i_credit,
    output logic                o_change500,
    output logic                o_change100,
    output logic                o_done,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam logic [CREDIT_W-1:0] C500 = CREDIT_W'(COIN_500);
    localparam logic [CREDIT_W-1:0] C100 = CREDIT_W'(COIN_100);

    // High when the current CHANGE cycle is a pulse slot rather than a gap.
    logic r_slot;
    logic w_pay;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot <= 1'b0;
        end else if (i_start) begin
            r_slot <= 1'b1;
        end else if (i_active) begin
            r_slot <= ~r_slot;
        end
    end

    always_comb begin
        w_pay       = i_active && r_slot && (i_credit != '0);
        o_change500 = w_pay && (i_credit >= C500);
        o_change100 = w_pay && (i_credit < C500);
        o_done      = i_active && (i_credit == '0);
        o_credit    = i_credit;
        if (o_change500) begin
            o_credit = i_credit - C500;
        end else if (o_change100) begin
            o_credit = i_credit - C100;
        end
    end

endmodule

// File: rtl/vending_controller.sv
// Vending machine sequencing FSM: accepts coins into a credit register,
// arbitrates simultaneous button pulses, times the dispense strobe and hands
// remaining credit to the change sequencer. All outputs are registered.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_coin100/500_pulse   : single-cycle coin-inserted pulses
//   i_select_pulse        : single-cycle buy request
//   i_cancel_pulse        : single-cycle refund request
//   o_credit              : current credit
//   o_dispense            : product strobe, DISPENSE_CYCLES cycles per sale
//   o_change500/100       : one pulse per coin returned
//   o_coin_reject         : coin not accepted
//   o_short_funds         : select with insufficient credit
//   o_state               : FSM state (IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3)
module vending_controller
    import vm_pkg::*;
#(
    parameter int unsigned PRICE           = 700,
    parameter int unsigned MAX_CREDIT      = 2000,
    parameter int unsigned CREDIT_W        = 12,
    parameter int unsigned DISPENSE_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_coin100_pulse,
    input  logic                i_coin500_pulse,
    input  logic                i_select_pulse,
    input  logic                i_cancel_pulse,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_dispense,
    output logic                o_change500,
    output logic                o_change100,
    output logic                o_coin_reject,
    output logic                o_short_funds,
    output logic [STATE_W-1:0]  o_state
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [SUM_W-1:0]    MAX_C   = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]    C100_S  = SUM_W'(COIN_100);
    localparam logic [SUM_W-1:0]    C500_S  = SUM_W'(COIN_500);
    localparam logic [CNT_W-1:0]    CNT_INI = CNT_W'(DISPENSE_CYCLES - 1);

    vm_state_e           r_state, w_state_d;
    logic [CREDIT_W-1:0] r_credit, w_credit_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                r_dispense, w_dispense_d;
    logic                r_change500, w_change500_d;
    logic                r_change100, w_change100_d;
    logic                r_reject, w_reject_d;
    logic                r_short, w_short_d;

    // Sums are one bit wider than the credit so an over-ceiling coin cannot wrap.
    logic [SUM_W-1:0]    w_sum100, w_sum500;
    logic                w_coin_any;

    logic                w_cu_start;
    logic                w_cu_500, w_cu_100, w_cu_done;
    logic [CREDIT_W-1:0] w_cu_credit;

    assign w_sum100   = {1'b0, r_credit} + C100_S;
    assign w_sum500   = {1'b0, r_credit} + C500_S;
    assign w_coin_any = i_coin100_pulse | i_coin500_pulse;
    assign w_cu_start = (w_state_d == CHANGE) && (r_state != CHANGE);

    vm_change_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_cu_start),
        .i_active    (r_state == CHANGE),
        .i_credit    (r_credit),
        .o_change500 (w_cu_500),
        .o_change100 (w_cu_100),
        .o_done      (w_cu_done),
        .o_credit    (w_cu_credit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_credit    <= '0;
            r_cnt       <= '0;
            r_dispense  <= 1'b0;
            r_change500 <= 1'b0;
            r_change100 <= 1'b0;
            r_reject    <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_credit    <= w_credit_d;
            r_cnt       <= w_cnt_d;
            r_dispense  <= w_dispense_d;
            r_change500 <= w_change500_d;
            r_change100 <= w_change100_d;
            r_reject    <= w_reject_d;
            r_short     <= w_short_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_credit_d    = r_credit;
        w_cnt_d       = r_cnt;
        w_dispense_d  = 1'b0;
        w_change500_d = 1'b0;
        w_change100_d = 1'b0;
        w_reject_d    = 1'b0;
        w_short_d     = 1'b0;

        unique case (r_state)
            IDLE, COLLECT: begin
                // One event per cycle: cancel > select > coin500 > coin100.
                if (i_cancel_pulse) begin
                    w_reject_d = w_coin_any;
                    if (r_credit != '0) begin
                        w_state_d = CHANGE;
                    end
                end else if (i_select_pulse) begin
                    w_reject_d = w_coin_any;
                    if (r_credit >= PRICE_C) begin
                        w_credit_d   = r_credit - PRICE_C;
                        w_state_d    = DISPENSE;
                        w_dispense_d = 1'b1;
                        w_cnt_d      = CNT_INI;
                    end else begin
                        w_short_d = 1'b1;
                    end
                end else if (i_coin500_pulse) begin
                    w_reject_d = i_coin100_pulse;
                    if (w_sum500 <= MAX_C) begin
                        w_credit_d = w_sum500[CREDIT_W-1:0];
                        w_state_d  = COLLECT;
                    end else begin
                        w_reject_d = 1'b1;
                    end
                end else if (i_coin100_pulse) begin
                    if (w_sum100 <= MAX_C) begin
                        w_credit_d = w_sum100[CREDIT_W-1:0];
                        w_state_d  = COLLECT;
                    end else begin
                        w_reject_d = 1'b1;
                    end
                end
            end

            DISPENSE: begin
                w_reject_d = w_coin_any;
                if (r_cnt == '0) begin
                    w_state_d = (r_credit != '0) ? CHANGE : IDLE;
                end else begin
                    w_cnt_d      = r_cnt - 1'b1;
                    w_dispense_d = 1'b1;
                end
            end

            CHANGE: begin
                w_reject_d    = w_coin_any;
                w_credit_d    = w_cu_credit;
                w_change500_d = w_cu_500;
                w_change100_d = w_cu_100;
                if (w_cu_done) begin
                    w_state_d = IDLE;
                end
            end
        endcase
    end

    assign o_credit      = r_credit;
    assign o_dispense    = r_dispense;
    assign o_change500   = r_change500;
    assign o_change100   = r_change100;
    assign o_coin_reject = r_reject;
    assign o_short_funds = r_short;
    assign o_state       = r_state;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: a per-cycle vector table covering
// reset, sales, refunds, ceiling and arbitration, plus hand-written sequences
// for dispense length and reset during change payout.
module tb_vending_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c100 = 1'b0;
    logic        c500 = 1'b0;
    logic        sel = 1'b0;
    logic        can = 1'b0;
    logic [11:0] o_credit;
    logic        o_dispense, o_change500, o_change100, o_coin_reject, o_short_funds;
    logic [1:0]  o_state;

    always #5 clk = ~clk;

    vending_controller #(
        .PRICE           (700),
        .MAX_CREDIT      (2000),
        .CREDIT_W        (12),
        .DISPENSE_CYCLES (4)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_coin100_pulse (c100),
        .i_coin500_pulse (c500),
        .i_select_pulse  (sel),
        .i_cancel_pulse  (can),
        .o_credit        (o_credit),
        .o_dispense      (o_dispense),
        .o_change500     (o_change500),
        .o_change100     (o_change100),
        .o_coin_reject   (o_coin_reject),
        .o_short_funds   (o_short_funds),
        .o_state         (o_state)
    );

    // Input codes {rst, coin100, coin500, select, cancel}
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] RS = 5'b10000;
    localparam logic [4:0] C1 = 5'b01000;
    localparam logic [4:0] C5 = 5'b00100;
    localparam logic [4:0] SL = 5'b00010;
    localparam logic [4:0] CN = 5'b00001;
    // Output codes {dispense, change500, change100, coin_reject, short_funds}
    localparam logic [4:0] O0 = 5'b00000;
    localparam logic [4:0] OD = 5'b10000;
    localparam logic [4:0] O5 = 5'b01000;
    localparam logic [4:0] O1 = 5'b00100;
    localparam logic [4:0] OR = 5'b00010;
    localparam logic [4:0] OS = 5'b00001;
    localparam int SI = 0, SC = 1, SD = 2, SX = 3;

    typedef struct {
        int          grp;
        logic [4:0]  ins;
        logic [11:0] credit;
        logic [1:0]  st;
        logic [4:0]  outs;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void add(input int g, input logic [4:0] ins, input int cr, input int st,
                                input logic [4:0] outs);
        vec_t v;
        v.grp    = g;
        v.ins    = ins;
        v.credit = 12'(cr);
        v.st     = 2'(st);
        v.outs   = outs;
        vecs.push_back(v);
    endfunction

    task automatic apply(input logic [4:0] ins);
        @(negedge clk);
        {rst, c100, c500, sel, can} = ins;
        @(posedge clk);
        #1;
        {rst, c100, c500, sel, can} = 5'b00000;
    endtask

    task automatic check_out(input string nm, input int idx, input logic [11:0] ecr,
                             input logic [1:0] est, input logic [4:0] eo);
        logic [4:0] got;
        got = {o_dispense, o_change500, o_change100, o_coin_reject, o_short_funds};
        checks++;
        if (o_credit !== ecr || o_state !== est || got !== eo) begin
            failures++;
            $display("FAIL %s[%0d] got credit=%0d state=%0d disp/c500/c100/rej/short=%b required credit=%0d state=%0d disp/c500/c100/rej/short=%b",
                     nm, idx, o_credit, o_state, got, ecr, est, eo);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    initial begin : main
        int dcnt, c5cnt, c1cnt, both, reached;

        // Reset, including a coin presented while reset is high.
        add(0, RS,      0,    SI, O0);
        add(0, RS | C5, 0,    SI, O0);
        // Buy with change: 500+500, select at 700, 300 returned as 3x100.
        add(1, C5,      500,  SC, O0);
        add(1, C5,      1000, SC, O0);
        add(1, SL,      300,  SD, OD);
        add(1, NO,      300,  SD, OD);
        add(1, NO,      300,  SD, OD);
        add(1, NO,      300,  SD, OD);
        add(1, NO,      300,  SX, O0);
        add(1, NO,      200,  SX, O1);
        add(1, NO,      200,  SX, O0);
        add(1, NO,      100,  SX, O1);
        add(1, NO,      100,  SX, O0);
        add(1, NO,      0,    SX, O1);
        add(1, NO,      0,    SI, O0);
        // Short funds, then refund.
        add(2, C1,      100,  SC, O0);
        add(2, C1,      200,  SC, O0);
        add(2, C1,      300,  SC, O0);
        add(2, SL,      300,  SC, OS);
        add(2, CN,      300,  SX, O0);
        add(2, NO,      200,  SX, O1);
        add(2, NO,      200,  SX, O0);
        add(2, NO,      100,  SX, O1);
        add(2, NO,      100,  SX, O0);
        add(2, NO,      0,    SX, O1);
        add(2, NO,      0,    SI, O0);
        // Credit ceiling.
        add(3, C5,      500,  SC, O0);
        add(3, C5,      1000, SC, O0);
        add(3, C5,      1500, SC, O0);
        add(3, C5,      2000, SC, O0);
        add(3, C1,      2000, SC, OR);
        add(3, C5,      2000, SC, OR);
        add(3, CN,      2000, SX, O0);
        add(3, NO,      1500, SX, O5);
        add(3, NO,      1500, SX, O0);
        add(3, NO,      1000, SX, O5);
        add(3, NO,      1000, SX, O0);
        add(3, NO,      500,  SX, O5);
        add(3, NO,      500,  SX, O0);
        add(3, NO,      0,    SX, O5);
        add(3, NO,      0,    SI, O0);
        // Simultaneous events.
        add(4, C5 | C1, 500,  SC, OR);
        add(4, CN | C1, 500,  SX, OR);
        add(4, NO,      0,    SX, O5);
        add(4, NO,      0,    SI, O0);
        // Cancel and select with zero credit in IDLE.
        add(5, CN,      0,    SI, O0);
        add(5, SL,      0,    SI, OS);
        // Exact-price sale goes straight back to IDLE.
        add(6, C5,      500,  SC, O0);
        add(6, C1,      600,  SC, O0);
        add(6, C1,      700,  SC, O0);
        add(6, SL,      0,    SD, OD);
        add(6, NO,      0,    SD, OD);
        add(6, NO,      0,    SD, OD);
        add(6, NO,      0,    SD, OD);
        add(6, NO,      0,    SI, O0);
        // Busy lockout in DISPENSE and CHANGE.
        add(7, C5,      500,  SC, O0);
        add(7, C5,      1000, SC, O0);
        add(7, SL,      300,  SD, OD);
        add(7, C1,      300,  SD, OD | OR);
        add(7, C5,      300,  SD, OD | OR);
        add(7, NO,      300,  SD, OD);
        add(7, NO,      300,  SX, O0);
        add(7, C1,      200,  SX, O1 | OR);
        add(7, SL,      200,  SX, O0);
        add(7, NO,      100,  SX, O1);
        add(7, CN,      100,  SX, O0);
        add(7, NO,      0,    SX, O1);
        add(7, NO,      0,    SI, O0);
        // Select beats coin; reset aborts a sale mid-dispense.
        add(8, C5,      500,  SC, O0);
        add(8, C5,      1000, SC, O0);
        add(8, SL | C5, 300,  SD, OD | OR);
        add(8, NO,      300,  SD, OD);
        add(8, RS,      0,    SI, O0);
        add(8, NO,      0,    SI, O0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].ins);
            check_out($sformatf("vec_g%0d", vecs[i].grp), i, vecs[i].credit, vecs[i].st,
                      vecs[i].outs);
        end

        // Count strobe cycles over a full sale with change.
        apply(C5);
        apply(C5);
        apply(SL);
        dcnt = int'(o_dispense);
        c5cnt = 0;
        c1cnt = 0;
        both = 0;
        reached = 0;
        for (int k = 0; k < 40; k++) begin
            apply(NO);
            dcnt  += int'(o_dispense);
            c5cnt += int'(o_change500);
            c1cnt += int'(o_change100);
            both  += int'(o_change500 & o_change100);
            if (o_state == 2'(SI)) begin
                reached = 1;
                break;
            end
        end
        check_int("sale_reached_idle", reached, 1);
        check_int("sale_dispense_cycles", dcnt, 4);
        check_int("sale_change100_count", c1cnt, 3);
        check_int("sale_change500_count", c5cnt, 0);
        check_int("sale_change_overlap", both, 0);
        check_int("sale_final_credit", int'(o_credit), 0);

        // Reset after the first change500 of a 1000 refund.
        apply(C5);
        apply(C5);
        apply(CN);
        check_out("rst_chg_enter", 0, 12'd1000, 2'(SX), O0);
        apply(NO);
        check_out("rst_chg_first", 0, 12'd500, 2'(SX), O5);
        apply(RS);
        check_out("rst_chg_reset", 0, 12'd0, 2'(SI), O0);
        c5cnt = 0;
        c1cnt = 0;
        for (int k = 0; k < 6; k++) begin
            apply(NO);
            c5cnt += int'(o_change500);
            c1cnt += int'(o_change100);
        end
        check_int("rst_chg_no_pulses", c5cnt + c1cnt, 0);
        check_out("rst_chg_after", 0, 12'd0, 2'(SI), O0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
